// File: rtl/cond_pkg.sv
// Shared types and constants for the condition-evaluation stage.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

  typedef enum logic {EMPTY, FULL} out_state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition code against {N,Z,C,V}.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c && !z;
      LS: cond_ex = !c || z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = !z && (n == v);
      LE: cond_ex = z || (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// NZCV flag register, condition gating of write requests and a one-entry
// valid/ready output register towards writeback.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pc_src,
  input  logic             reg_write,
  input  logic             mem_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pc_src_q,
  output logic             reg_write_q,
  output logic             mem_write_q,
  output logic             cond_ex_q,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] ovf_count
);

  out_state_e state;
  logic       pass;
  logic       accept;
  logic       transfer;

  // Condition sees the committed flags only; there is no alu_flags bypass.
  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (pass)
  );

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      flags_q     <= '0;
      ovf_count   <= '0;
    end else if (accept) begin
      state       <= FULL;
      pc_src_q    <= pc_src && pass;
      reg_write_q <= reg_write && pass;
      mem_write_q <= mem_write && pass;
      cond_ex_q   <= pass;
      if (pass) begin
        if (flag_w[FW_NZ]) begin
          flags_q[FLAG_N] <= alu_flags[FLAG_N];
          flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
        end
        if (flag_w[FW_CV]) begin
          flags_q[FLAG_C] <= alu_flags[FLAG_C];
          flags_q[FLAG_V] <= alu_flags[FLAG_V];
          if (alu_flags[FLAG_V] && (ovf_count != '1))
            ovf_count <= ovf_count + 1'b1;
        end
      end
    end else if (transfer) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Randomized self-checking bench for cond_exec_unit against a behavioural model.
module tb_cond_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] cond = '0;
  logic [3:0] alu_flags = '0;
  logic [1:0] flag_w = '0;
  logic       pc_src = 1'b0, reg_write = 1'b0, mem_write = 1'b0;

  logic       in_ready, out_valid, pc_src_q, reg_write_q, mem_write_q, cond_ex_q;
  logic [3:0] flags_q;
  logic [7:0] ovf_count;

  logic       d2_in_ready, d2_out_valid, d2_pc_src_q, d2_reg_write_q, d2_mem_write_q, d2_cond_ex_q;
  logic [3:0] d2_flags_q;
  logic [1:0] d2_ovf_count;

  logic [3:0] cc_cond, cc_flags;
  logic       cc_ex;

  int checks = 0;
  int errors = 0;

  // model state
  logic       m_valid, m_pc, m_rw, m_mw, m_cx;
  logic [3:0] m_flags;
  int         m_ovf8, m_ovf2;

  always #5 clk = ~clk;

  cond_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w),
    .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_src_q(pc_src_q), .reg_write_q(reg_write_q), .mem_write_q(mem_write_q),
    .cond_ex_q(cond_ex_q), .flags_q(flags_q), .ovf_count(ovf_count)
  );

  cond_exec_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
    .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w),
    .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
    .out_valid(d2_out_valid), .out_ready(out_ready),
    .pc_src_q(d2_pc_src_q), .reg_write_q(d2_reg_write_q), .mem_write_q(d2_mem_write_q),
    .cond_ex_q(d2_cond_ex_q), .flags_q(d2_flags_q), .ovf_count(d2_ovf_count)
  );

  cond_check u_cc (.cond(cc_cond), .flags(cc_flags), .cond_ex(cc_ex));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Base test on cond[3:1], odd codes invert it; 1111 never executes.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_rw = 0; m_mw = 0; m_cx = 0;
    m_flags = '0; m_ovf8 = 0; m_ovf2 = 0;
  endtask

  task automatic compare_all(input string ph);
    check({ph, "_out_valid"}, out_valid, m_valid);
    check({ph, "_pc_src_q"}, pc_src_q, m_pc);
    check({ph, "_reg_write_q"}, reg_write_q, m_rw);
    check({ph, "_mem_write_q"}, mem_write_q, m_mw);
    check({ph, "_cond_ex_q"}, cond_ex_q, m_cx);
    check({ph, "_flags_q"}, flags_q, m_flags);
    check({ph, "_ovf8"}, ovf_count, m_ovf8);
    check({ph, "_ovf2"}, d2_ovf_count, m_ovf2);
    check({ph, "_d2_flags"}, d2_flags_q, m_flags);
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic pc, input logic rw,
                       input logic mw, input logic rdy);
    in_valid = v; cond = c; alu_flags = af; flag_w = fw;
    pc_src = pc; reg_write = rw; mem_write = mw; out_ready = rdy;
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic cycle(input string ph);
    logic acc, p;
    #1;
    check({ph, "_in_ready"}, in_ready, !m_valid || out_ready);
    acc = in_valid && (!m_valid || out_ready);
    p = ref_pass(cond, m_flags);
    @(posedge clk);
    if (acc) begin
      m_valid = 1; m_cx = p;
      m_pc = pc_src & p; m_rw = reg_write & p; m_mw = mem_write & p;
      if (p) begin
        if (flag_w[1]) m_flags[3:2] = alu_flags[3:2];
        if (flag_w[0]) begin
          m_flags[1:0] = alu_flags[1:0];
          if (alu_flags[0]) begin
            m_ovf8 = (m_ovf8 < 255) ? m_ovf8 + 1 : 255;
            m_ovf2 = (m_ovf2 < 3) ? m_ovf2 + 1 : 3;
          end
        end
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    compare_all(ph);
  endtask

  initial begin
    logic [3:0] snap_flags;
    logic [7:0] snap_ovf;
    logic       snap_rw;

    model_reset();
    // standalone condition table sweep
    for (int unsigned i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = i[7:0];
      cc_cond = iv[7:4]; cc_flags = iv[3:0];
      #1;
      check("cond_check", cc_ex, ref_pass(cc_cond, cc_flags));
    end

    repeat (2) @(negedge clk);
    compare_all("reset");
    check("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // first instruction
    drive(1, 4'b1110, 4'b1001, 2'b11, 0, 1, 0, 1);
    cycle("t1");
    check("t1_flags_const", flags_q, 4'b1001);
    check("t1_ovf_const", ovf_count, 8'd1);
    check("t1_rw_const", reg_write_q, 1'b1);

    // Z set, then EQ passes and NE fails
    drive(1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 1); cycle("setz");
    drive(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 1); cycle("eq");
    check("eq_pc_const", pc_src_q, 1'b1);
    drive(1, 4'b0001, 4'b1111, 2'b11, 1, 1, 1, 1); cycle("ne");
    check("ne_cx_const", cond_ex_q, 1'b0);
    check("ne_flags_const", flags_q, 4'b0100);

    // partial C/V write
    drive(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 1); cycle("set1111");
    drive(1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 1); cycle("partial");
    check("partial_const", flags_q, 4'b1100);

    // back-to-back, no forwarding needed beyond committed flags
    drive(1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 1); cycle("b2b_a");
    drive(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 1); cycle("b2b_b");
    check("b2b_mw_const", mem_write_q, 1'b1);

    // backpressure while FULL
    snap_flags = flags_q; snap_ovf = ovf_count; snap_rw = reg_write_q;
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'b1110, 4'b1011, 2'b11, 0, 1, 0, 0);
      cycle("bp");
      check("bp_flags_stable", flags_q, snap_flags);
      check("bp_ovf_stable", ovf_count, snap_ovf);
      check("bp_rw_stable", reg_write_q, snap_rw);
      check("bp_in_ready", in_ready, 1'b0);
    end
    drive(1, 4'b1110, 4'b1011, 2'b11, 0, 1, 0, 1); cycle("bp_release");
    check("bp_release_flags", flags_q, 4'b1011);

    // saturation on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'b1110, 4'b0001, 2'b01, 0, 0, 0, 1);
      cycle("sat");
    end
    check("sat_ovf2_const", d2_ovf_count, 2'd3);

    // randomized traffic with one asynchronous reset in the middle
    for (int k = 0; k < 600; k++) begin
      if (k == 300) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check("async_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
